// File: rtl/fpga_cfg_pkg.sv
// Shared configuration for the QMC path generator: datapath width,
// sequencer FSM states and the in-flight tag carried beside each request.
package fpga_cfg_pkg;

    localparam int FP_WIDTH  = 16;
    // The tag carries dimensions up to 2^TAG_DIM_W-1; M must stay within that.
    localparam int TAG_DIM_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    // Tag index is FP_WIDTH wide; sequencer WIDTH must not exceed FP_WIDTH.
    typedef struct packed {
        logic [FP_WIDTH-1:0]  idx;
        logic [TAG_DIM_W-1:0] dim;
        logic                 last;
    } seq_tag_t;

endpackage

// File: rtl/seq_tag_fifo.sv
// In-order tag FIFO: synchronous push/pop, show-ahead head, full/empty flags.
// A push while full is accepted only when a pop happens in the same cycle.
module seq_tag_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_q, rd_q;
    logic          do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // Storage write; contents need no reset since empty_o guards the head.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

    // Read/write pointers with wrap bit for full/empty disambiguation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/sobol_sequencer.sv
// Request-side driver for one Sobol lane: walks (path, dim) pairs, issues
// one request per pair, and tags each returned coordinate in order.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; start with num_paths=0 just pulses done
//   ST_RUN   | issuing requests, path-major, dim 0..M-1
//   ST_DRAIN | all requests issued, forwarding remaining responses
module sobol_sequencer
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH      = FP_WIDTH,
    parameter int M          = 50,
    parameter int LANE_ID    = 0,
    parameter int LANE_COUNT = 1,
    parameter int TAG_DEPTH  = 4,
    localparam int DIM_W     = (M > 1) ? $clog2(M) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base_idx,
    input  logic [WIDTH-1:0] num_paths,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [WIDTH-1:0] req_idx,
    output logic [DIM_W-1:0] req_dim,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [WIDTH-1:0] rsp_sobol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sobol,
    output logic [WIDTH-1:0] out_idx,
    output logic [DIM_W-1:0] out_dim,
    output logic             out_last
);

    seq_state_e       state_q;
    logic [WIDTH-1:0] idx_q, path_q, paths_q;
    logic [DIM_W-1:0] dim_q;
    logic             done_q, err_q;

    logic     fifo_full, fifo_empty, req_fire, pop, last_dim, last_path;
    seq_tag_t push_tag, head_tag;

    assign last_dim  = (dim_q == DIM_W'(M - 1));
    assign last_path = (path_q == paths_q - WIDTH'(1));
    assign req_valid = (state_q == ST_RUN) && !fifo_full;
    assign req_fire  = req_valid && req_ready;
    assign req_idx   = idx_q;
    assign req_dim   = dim_q;

    assign push_tag.idx  = FP_WIDTH'(idx_q);
    assign push_tag.dim  = TAG_DIM_W'(dim_q);
    assign push_tag.last = last_dim && last_path;

    // A response with no pending tag is swallowed so the lane never stalls.
    assign rsp_ready = fifo_empty ? 1'b1 : out_ready;
    assign out_valid = !fifo_empty && rsp_valid;
    assign pop       = out_valid && out_ready;
    assign out_sobol = fifo_empty ? '0 : rsp_sobol;
    assign out_idx   = fifo_empty ? '0 : WIDTH'(head_tag.idx);
    assign out_dim   = fifo_empty ? '0 : DIM_W'(head_tag.dim);
    assign out_last  = !fifo_empty && head_tag.last;

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign err  = err_q;

    seq_tag_fifo #(
        .DW    ($bits(seq_tag_t)),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (req_fire),
        .data_i  (push_tag),
        .pop_i   (pop),
        .data_o  (head_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Sequencing FSM with index accumulator, done pulse and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            path_q  <= '0;
            paths_q <= '0;
            dim_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (rsp_valid && fifo_empty) err_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (num_paths == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            idx_q   <= base_idx + WIDTH'(LANE_ID);
                            path_q  <= '0;
                            paths_q <= num_paths;
                            dim_q   <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (req_fire) begin
                        if (last_dim) begin
                            dim_q  <= '0;
                            path_q <= path_q + WIDTH'(1);
                            idx_q  <= idx_q + WIDTH'(LANE_COUNT);
                            if (last_path) state_q <= ST_DRAIN;
                        end else begin
                            dim_q <= dim_q + DIM_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && head_tag.last) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobol_sequencer.sv
// Directed bench for sobol_sequencer: two lanes (offset/stride variants),
// a 1-cycle-latency Sobol lane model and an output scoreboard.
module tb_sobol_sequencer;

    localparam int W = 16;

    typedef struct packed {
        logic [15:0] sobol;
        logic [15:0] idx;
        logic [1:0]  dim;
        logic        last;
        int          cyc;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start     [2];
    logic [15:0] base_idx  [2];
    logic [15:0] num_paths [2];
    logic        busy      [2];
    logic        done      [2];
    logic        err       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [15:0] req_idx   [2];
    logic [1:0]  req_dim   [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_sobol [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [15:0] out_sobol [2];
    logic [15:0] out_idx   [2];
    logic [1:0]  out_dim   [2];
    logic        out_last  [2];

    logic inj = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    out_t oq0[$];
    out_t oq1[$];
    int   done_cnt[2];
    int   done_cyc[2];
    int   last_cyc[2];
    logic busy_at_done[2];

    always #5 clk = ~clk;

    sobol_sequencer #(.WIDTH(W), .M(4), .LANE_ID(0), .LANE_COUNT(1), .TAG_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .base_idx(base_idx[0]),
        .num_paths(num_paths[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_idx(req_idx[0]),
        .req_dim(req_dim[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_sobol(rsp_sobol[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sobol(out_sobol[0]), .out_idx(out_idx[0]), .out_dim(out_dim[0]),
        .out_last(out_last[0]));

    sobol_sequencer #(.WIDTH(W), .M(4), .LANE_ID(1), .LANE_COUNT(4), .TAG_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .base_idx(base_idx[1]),
        .num_paths(num_paths[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_idx(req_idx[1]),
        .req_dim(req_dim[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_sobol(rsp_sobol[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sobol(out_sobol[1]), .out_idx(out_idx[1]), .out_dim(out_dim[1]),
        .out_last(out_last[1]));

    function automatic logic [15:0] sobol_fn(input logic [15:0] i, input logic [1:0] d);
        return i ^ {d, 14'h0} ^ 16'h5A3C;
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic go(input int d, input logic [15:0] base, input logic [15:0] num);
        if (d == 0) oq0.delete(); else oq1.delete();
        start[d]     = 1'b1;
        base_idx[d]  = base;
        num_paths[d] = num;
        tick(1);
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        int c0 = done_cnt[d];
        int n = 0;
        while (done_cnt[d] == c0 && n < budget) begin
            tick(1);
            n++;
        end
        if (done_cnt[d] == c0) chk_val($sformatf("timeout_lane%0d", d), 32'd0, 32'd1);
        tick(1);
    endtask

    task automatic chk_seq(input int d, input int n, input logic [15:0] base,
                           input logic [15:0] stride);
        int got;
        out_t o;
        logic [15:0] e_idx;
        logic [1:0]  e_dim;
        got = (d == 0) ? oq0.size() : oq1.size();
        chk_val($sformatf("n_out_lane%0d", d), got, n);
        for (int i = 0; i < n && i < got; i++) begin
            o = (d == 0) ? oq0[i] : oq1[i];
            e_idx = base + 16'(i / 4) * stride;
            e_dim = 2'(i % 4);
            chk_val($sformatf("idx[%0d]", i), o.idx, e_idx);
            chk_val($sformatf("dim[%0d]", i), o.dim, e_dim);
            chk_val($sformatf("last[%0d]", i), o.last, i == n - 1);
            chk_val($sformatf("sobol[%0d]", i), o.sobol, sobol_fn(e_idx, e_dim));
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sobol lane model: 1-cycle latency, in-order responses held until taken.
    initial begin
        logic [15:0] q0[$];
        logic [15:0] q1[$];
        logic rf0, rf1, pf0, pf1;
        logic [15:0] s0, s1;
        rsp_valid[0] = 1'b0; rsp_valid[1] = 1'b0;
        rsp_sobol[0] = '0;   rsp_sobol[1] = '0;
        forever begin
            @(negedge clk);
            rf0 = req_valid[0] && req_ready[0];
            rf1 = req_valid[1] && req_ready[1];
            pf0 = rsp_valid[0] && rsp_ready[0];
            pf1 = rsp_valid[1] && rsp_ready[1];
            s0  = sobol_fn(req_idx[0], req_dim[0]);
            s1  = sobol_fn(req_idx[1], req_dim[1]);
            @(posedge clk);
            #1;
            if (pf0 && q0.size() != 0) void'(q0.pop_front());
            if (pf1 && q1.size() != 0) void'(q1.pop_front());
            if (rf0) q0.push_back(s0);
            if (rf1) q1.push_back(s1);
            if (!rst_n) begin
                q0.delete();
                q1.delete();
            end
            rsp_valid[0] = (q0.size() != 0) || inj;
            rsp_valid[1] = (q1.size() != 0);
            rsp_sobol[0] = (q0.size() != 0) ? q0[0] : 16'hDEAD;
            rsp_sobol[1] = (q1.size() != 0) ? q1[0] : 16'h0;
        end
    end

    // Output scoreboard capture and done/busy bookkeeping.
    initial begin
        out_t s;
        done_cnt[0] = 0; done_cnt[1] = 0;
        done_cyc[0] = 0; done_cyc[1] = 0;
        last_cyc[0] = 0; last_cyc[1] = 0;
        busy_at_done[0] = 1'b0; busy_at_done[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_n && out_valid[d] && out_ready[d]) begin
                    s = '{sobol: out_sobol[d], idx: out_idx[d], dim: out_dim[d],
                          last: out_last[d], cyc: cyc};
                    if (d == 0) oq0.push_back(s); else oq1.push_back(s);
                    if (out_last[d]) last_cyc[d] = cyc;
                end
                if (done[d]) begin
                    done_cnt[d]++;
                    done_cyc[d] = cyc;
                    busy_at_done[d] = busy[d];
                end
            end
        end
    end

    initial begin
        int n0, k, dc;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; base_idx[d] = '0; num_paths[d] = '0;
            req_ready[d] = 1'b1; out_ready[d] = 1'b1;
        end

        // reset state
        #12;
        chk_val("rst_busy", busy[0], 0);
        chk_val("rst_done", done[0], 0);
        chk_val("rst_err", err[0], 0);
        chk_val("rst_req_valid", req_valid[0], 0);
        chk_val("rst_out_valid", out_valid[0], 0);
        chk_val("rst_req_idx", req_idx[0], 0);
        chk_val("rst_out_idx", out_idx[0], 0);
        chk_val("rst_out_sobol", out_sobol[0], 0);
        chk_val("rst_out_last", out_last[0], 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // basic run: base 1, 2 paths, M=4
        go(0, 16'd1, 16'd2);
        wait_done(0, 300);
        chk_seq(0, 8, 16'd1, 16'd1);
        if (oq0.size() == 8) begin
            chk_val("idx_path0", oq0[3].idx, 16'd1);
            chk_val("idx_path1", oq0[4].idx, 16'd2);
            chk_val("throughput", oq0[7].cyc - oq0[0].cyc, 7);
        end
        chk_val("done_latency", done_cyc[0] - last_cyc[0], 1);
        chk_val("busy_at_done", busy_at_done[0], 0);
        chk_val("done_count", done_cnt[0], 1);

        // lane offset and stride: idx 2, 6, 10
        go(1, 16'd1, 16'd3);
        wait_done(1, 300);
        chk_seq(1, 12, 16'd2, 16'd4);
        if (oq1.size() == 12) begin
            chk_val("lane1_idx_p0", oq1[0].idx, 16'd2);
            chk_val("lane1_idx_p1", oq1[4].idx, 16'd6);
            chk_val("lane1_idx_p2", oq1[8].idx, 16'd10);
        end

        // num_paths = 0
        start[0] = 1'b1; num_paths[0] = 16'd0; base_idx[0] = 16'd9;
        dc = done_cnt[0];
        @(negedge clk);
        chk_val("np0_done_c0", done[0], 0);
        @(posedge clk); #2;
        start[0] = 1'b0;
        @(negedge clk);
        chk_val("np0_done_c1", done[0], 1);
        chk_val("np0_busy", busy[0], 0);
        chk_val("np0_req_valid", req_valid[0], 0);
        @(negedge clk);
        chk_val("np0_done_c2", done[0], 0);
        chk_val("np0_done_cnt", done_cnt[0] - dc, 1);
        @(posedge clk); #2;

        // backpressure: out_ready low for 10 cycles mid-run
        go(0, 16'h0010, 16'd3);
        tick(2);
        out_ready[0] = 1'b0;
        tick(5);
        n0 = oq0.size();
        k  = n0 + 4;
        chk_val("bp_req_valid_a", req_valid[0], 0);
        chk_val("bp_req_idx_a", req_idx[0], 16'h0010 + 16'(k / 4));
        chk_val("bp_req_dim_a", req_dim[0], 2'(k % 4));
        tick(5);
        chk_val("bp_req_valid_b", req_valid[0], 0);
        chk_val("bp_req_idx_b", req_idx[0], 16'h0010 + 16'(k / 4));
        chk_val("bp_req_dim_b", req_dim[0], 2'(k % 4));
        chk_val("bp_no_out", oq0.size(), n0);
        out_ready[0] = 1'b1;
        wait_done(0, 300);
        chk_seq(0, 12, 16'h0010, 16'd1);

        // stray response in IDLE sets sticky err
        oq0.delete();
        chk_val("err_before", err[0], 0);
        inj = 1'b1;
        tick(1);
        inj = 1'b0;
        chk_val("err_out_valid", out_valid[0], 0);
        chk_val("err_rsp_ready", rsp_ready[0], 1);
        tick(1);
        chk_val("err_set", err[0], 1);
        tick(5);
        chk_val("err_sticky", err[0], 1);
        chk_val("err_no_output", oq0.size(), 0);
        rst_n = 1'b0;
        #3;
        chk_val("err_cleared", err[0], 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // index wrap-around
        go(0, 16'hFFFF, 16'd2);
        wait_done(0, 300);
        chk_seq(0, 8, 16'hFFFF, 16'd1);
        if (oq0.size() == 8) begin
            chk_val("wrap_p0", oq0[0].idx, 16'hFFFF);
            chk_val("wrap_p1", oq0[4].idx, 16'h0000);
        end

        // reset during RUN, then a clean restart
        go(0, 16'd5, 16'd3);
        tick(3);
        chk_val("mid_busy_pre", busy[0], 1);
        dc = done_cnt[0];
        rst_n = 1'b0;
        #1;
        chk_val("mid_busy", busy[0], 0);
        chk_val("mid_req_valid", req_valid[0], 0);
        chk_val("mid_out_valid", out_valid[0], 0);
        chk_val("mid_req_idx", req_idx[0], 0);
        chk_val("mid_out_idx", out_idx[0], 0);
        chk_val("mid_out_sobol", out_sobol[0], 0);
        chk_val("mid_done", done[0], 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk_val("mid_no_done", done_cnt[0] - dc, 0);
        go(0, 16'd7, 16'd1);
        wait_done(0, 300);
        chk_seq(0, 4, 16'd7, 16'd1);
        chk_val("restart_err", err[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
